idli_issue_ctrl_m: RTL and testbench
====================================

# idli_issue_ctrl_m

Sequences decoded instructions from the 4b-per-cycle decoder into the execute stage. It assembles trailing 16b immediates and buffers complete instructions in a small FIFO. It gates fetch at instruction boundaries so the FIFO never overflows, and flushes everything on an execute redirect. It sits between fetch/decode and execute, and is the single point of flow control for the front end.

## Interface
Parameters:
- DEPTH, 2, number of complete-instruction FIFO entries (power of two, ≥2).

Ports:
- i_dcd_gck  input  1  gated core clock, all flops on posedge.
- i_dcd_rst_n  input  1  reset; asynchronous, active-low.
- i_dcd_enc  input  4  nibble presented to the decoder (sqi_data_t).
- i_dcd_enc_vld  input  1  nibble valid, identical to the decoder's enable.
- i_dcd_op  input  op_t  decoded op from the decoder (combinational, final cycle).
- i_dcd_op_vld  input  1  decoded op valid (NOPs and immediate cycles already suppressed).
- i_ex_redirect  input  1  execute redirect; also drives the decoder's redirect input.
- o_fetch_en  output  1  fetch may start a new instruction; sampled by fetch only at instruction boundaries.
- o_iss_op  output  op_t  head FIFO entry op.
- o_iss_imm  output  16  head FIFO entry immediate; zero when rhs_src != RHS_SRC_IMM.
- o_iss_vld  output  1  head entry valid.
- i_iss_rdy  input  1  execute accepts head; a pop occurs when o_iss_vld && i_iss_rdy.

## Operation
- Nibble counter nib_q[1:0] increments on every i_dcd_enc_vld. An instruction boundary is nib_q==0 in state OP.
- State machine, 2 states:
  - OP: counting opcode nibbles.
    - If i_dcd_op_vld and i_dcd_op.rhs_src==RHS_SRC_IMM: latch the op into the pending register, clear the immediate shifter, go to IMM.
    - If i_dcd_op_vld without an immediate: push the op with imm=0.
    - A 4-nibble NOP pushes nothing and returns nib_q to 0.
  - IMM: each valid nibble fills imm[4*nib_q +: 4], least-significant nibble first. On the 4th nibble (nib_q==3), push {pending op, assembled imm} and go to OP.
- FIFO: DEPTH entries with read/write pointers plus a count of width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave the count unchanged. This is legal when full, since a pop frees the slot.
- Credit rule: o_fetch_en = (count + inflight) < DEPTH.
  - inflight = 1 when nib_q!=0 or state==IMM; otherwise 0.
  - The count is the flopped value; a pop in the current cycle does not raise o_fetch_en until the next cycle.
  - A push onto a full FIFO is a design error; an assertion fires in simulation.
- Redirect (i_ex_redirect=1), highest priority over push and pop in the same cycle:
  - count, pointers and nib_q are cleared and state returns to OP.
  - The pending op is discarded, and any push that cycle is dropped.
  - An execute pop asserted in the same cycle is still considered consumed by execute; FIFO state is cleared regardless.
- Decoder output is only trusted when i_dcd_op_vld=1. Fields of op_t are stored without modification.

## Timing
- Reset values:
  - o_iss_vld=0, o_fetch_en=1, o_iss_imm=0.
  - o_iss_op follows entry 0; entry contents are not reset.
  - state=OP, nib_q=0, count=0.
- Latency, non-immediate: op valid in cycle N (4th nibble), o_iss_vld=1 in cycle N+1 with the FIFO empty.
- Latency, immediate: last immediate nibble in cycle N+4, issue in cycle N+5.
- o_iss_vld and o_iss_op/imm are driven from flops (head entry); there is no combinational path from i_dcd_op to outputs.
- o_fetch_en is combinational from flops only.
- Redirect takes effect in the following cycle: o_iss_vld=0 and o_fetch_en=1.

## Structure
- Add to idli_pkg:
  - issue_ent_t, a packed struct {op_t op; logic [15:0] imm;}.
  - state enum iss_state_t {ISS_STATE_OP, ISS_STATE_IMM}.
- Sub-module idli_issue_fifo_m, parameterised by DEPTH and the entry type: storage, pointers, count, full/empty.
- Immediate assembly, credit logic and FSM stay in the top module.

## Test plan
- Reset mid-instruction (nib_q=2, state IMM) -> all outputs at reset values; first nibble after release is treated as opcode nibble 0.
- ADD with register C, i_iss_rdy=1 -> o_iss_vld pulses 1 cycle after op_vld, o_iss_imm=0x0000, op fields unchanged.
- ADD with immediate, nibbles 0x4,0x3,0x2,0x1 -> single issue with o_iss_imm=0x1234, one cycle after the last nibble; no issue during the immediate cycles.
- DEPTH=2, i_iss_rdy=0, three back-to-back instructions -> o_fetch_en drops when count+inflight=2, third instruction held. Raise rdy: pop, o_fetch_en=1 the next cycle, and the FIFO order is preserved.
- Push and pop in the same cycle with count=1 -> count stays 1; the head advances to the newer entry.
- i_ex_redirect during immediate nibble 2, with FIFO holding 1 entry and a simultaneous pop -> next cycle o_iss_vld=0, count=0, o_fetch_en=1. The next instruction decodes and issues normally with the correct immediate.

Source files
------------

// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared types for the idli front end and issue path
//
// Purpose: decoder op encoding, issue FIFO entry and issue FSM state types.
// Ports: none (package).
package idli_pkg;

  typedef logic [3:0] sqi_data_t;
  typedef logic [1:0] greg_t;

  typedef enum logic [3:0] {
    ALU_OP_ADD = 4'h0,
    ALU_OP_SUB = 4'h1,
    ALU_OP_AND = 4'h2,
    ALU_OP_OR  = 4'h3,
    ALU_OP_XOR = 4'h4,
    ALU_OP_SHL = 4'h5
  } alu_op_t;

  typedef enum logic [1:0] {
    RHS_SRC_REG  = 2'd0,
    RHS_SRC_IMM  = 2'd1,
    RHS_SRC_ZERO = 2'd2,
    RHS_SRC_PC   = 2'd3
  } rhs_src_t;

  typedef struct packed {
    alu_op_t  alu_op;
    greg_t    dst;
    greg_t    lhs;
    rhs_src_t rhs_src;
    greg_t    rhs;
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [15:0] imm;
  } issue_ent_t;

  typedef enum logic {
    ISS_STATE_OP  = 1'b0,
    ISS_STATE_IMM = 1'b1
  } iss_state_t;

endpackage

// File: rtl/idli_issue_fifo_m.sv
// rtl/idli_issue_fifo_m.sv - complete-instruction FIFO for the issue controller
//
// Purpose: DEPTH-entry FIFO with wrapping pointers and an occupancy count.
// Ports:
//   i_dcd_gck / i_dcd_rst_n  clock, async active-low reset
//   i_clr                    synchronous flush of pointers and count
//   i_push / i_push_ent      write an entry at the tail
//   i_pop                    drop the head entry
//   o_head                   head entry (entry 0 after reset)
//   o_count                  number of valid entries
//   o_empty                  no valid entries
module idli_issue_fifo_m
  import idli_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type ent_t = issue_ent_t
) (
  input  logic                       i_dcd_gck,
  input  logic                       i_dcd_rst_n,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  ent_t                       i_push_ent,
  input  logic                       i_pop,
  output ent_t                       o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ent_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            full;

  assign full    = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (i_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (i_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({i_push, i_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_dcd_gck) begin
    if (i_push && !i_clr) mem_q[wr_ptr_q] <= i_push_ent;
  end

  // Pushing while full is only legal when the head leaves in the same cycle.
  a_no_overflow: assert property (@(posedge i_dcd_gck) disable iff (!i_dcd_rst_n)
    !(i_push && full && !i_pop && !i_clr));

endmodule

// File: rtl/idli_issue_ctrl_m.sv
// rtl/idli_issue_ctrl_m.sv - decode-to-execute issue sequencer
//
// Purpose: assembles trailing 16b immediates, buffers complete instructions,
// gates fetch on FIFO credit and flushes on execute redirect.
// Ports:
//   i_dcd_gck / i_dcd_rst_n   clock, async active-low reset
//   i_dcd_enc / i_dcd_enc_vld decoder nibble and its valid
//   i_dcd_op / i_dcd_op_vld   decoded op on its final nibble
//   i_ex_redirect             flush everything
//   o_fetch_en                fetch may begin a new instruction
//   o_iss_op/imm/vld          head instruction toward execute
//   i_iss_rdy                 execute accepts the head
module idli_issue_ctrl_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        i_dcd_gck,
  input  logic        i_dcd_rst_n,
  input  sqi_data_t   i_dcd_enc,
  input  logic        i_dcd_enc_vld,
  input  op_t         i_dcd_op,
  input  logic        i_dcd_op_vld,
  input  logic        i_ex_redirect,
  output logic        o_fetch_en,
  output op_t         o_iss_op,
  output logic [15:0] o_iss_imm,
  output logic        o_iss_vld,
  input  logic        i_iss_rdy
);

  localparam int CW = $clog2(DEPTH) + 1;

  iss_state_t    state_q, state_d;
  logic [1:0]    nib_q;
  op_t           pend_q;
  logic [15:0]   imm_q;
  logic          push;
  issue_ent_t    push_ent;
  logic          pop;
  issue_ent_t    head;
  logic [CW-1:0] count;
  logic          empty;
  logic          inflight;
  logic [CW:0]   credit_used;
  logic          op_has_imm;

  assign op_has_imm = i_dcd_op_vld && (i_dcd_op.rhs_src == RHS_SRC_IMM);

  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n)       state_q <= ISS_STATE_OP;
    else if (i_ex_redirect) state_q <= ISS_STATE_OP;
    else                    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISS_STATE_OP:  if (op_has_imm) state_d = ISS_STATE_IMM;
      ISS_STATE_IMM: if (i_dcd_enc_vld && nib_q == 2'd3) state_d = ISS_STATE_OP;
      default:       state_d = ISS_STATE_OP;
    endcase
  end

  // A redirect drops whatever would have been pushed this cycle.
  always_comb begin
    push         = 1'b0;
    push_ent.op  = i_dcd_op;
    push_ent.imm = '0;
    case (state_q)
      ISS_STATE_OP: begin
        push = i_dcd_op_vld && !op_has_imm && !i_ex_redirect;
      end
      ISS_STATE_IMM: begin
        push_ent.op  = pend_q;
        push_ent.imm = {i_dcd_enc, imm_q[11:0]};
        push         = i_dcd_enc_vld && (nib_q == 2'd3) && !i_ex_redirect;
      end
      default: push = 1'b0;
    endcase
  end

  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n)       nib_q <= '0;
    else if (i_ex_redirect) nib_q <= '0;
    else if (i_dcd_enc_vld) nib_q <= nib_q + 1'b1;
  end

  // Immediate is collected least-significant nibble first.
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      pend_q <= '0;
      imm_q  <= '0;
    end else if (state_q == ISS_STATE_OP && op_has_imm) begin
      pend_q <= i_dcd_op;
      imm_q  <= '0;
    end else if (state_q == ISS_STATE_IMM && i_dcd_enc_vld) begin
      imm_q[{nib_q, 2'b00} +: 4] <= i_dcd_enc;
    end
  end

  assign pop = o_iss_vld && i_iss_rdy;

  idli_issue_fifo_m #(
    .DEPTH (DEPTH),
    .ent_t (issue_ent_t)
  ) u_fifo (
    .i_dcd_gck   (i_dcd_gck),
    .i_dcd_rst_n (i_dcd_rst_n),
    .i_clr       (i_ex_redirect),
    .i_push      (push),
    .i_push_ent  (push_ent),
    .i_pop       (pop),
    .o_head      (head),
    .o_count     (count),
    .o_empty     (empty)
  );

  // A partially fetched instruction already holds a credit.
  assign inflight    = (nib_q != 2'd0) || (state_q == ISS_STATE_IMM);
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign o_fetch_en  = credit_used < (CW + 1)'(DEPTH);

  assign o_iss_vld = !empty;
  assign o_iss_op  = head.op;
  assign o_iss_imm = (o_iss_vld && head.op.rhs_src == RHS_SRC_IMM) ? head.imm : 16'h0000;

endmodule

// File: tb/tb_idli_issue_ctrl_m.sv
// tb/tb_idli_issue_ctrl_m.sv - directed scoreboard bench for idli_issue_ctrl_m
module tb_idli_issue_ctrl_m;
  import idli_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  sqi_data_t   enc = '0;
  logic        enc_vld = 1'b0;
  op_t         op = '0;
  logic        op_vld = 1'b0;
  logic        redirect = 1'b0;
  logic        rdy = 1'b0;
  logic        fetch_en;
  op_t         iss_op;
  logic [15:0] iss_imm;
  logic        iss_vld;

  issue_ent_t  exp_q[$];
  issue_ent_t  got;
  int          nerr = 0;
  int          nchk = 0;

  idli_issue_ctrl_m #(.DEPTH(2)) dut (
    .i_dcd_gck     (clk),
    .i_dcd_rst_n   (rst_n),
    .i_dcd_enc     (enc),
    .i_dcd_enc_vld (enc_vld),
    .i_dcd_op      (op),
    .i_dcd_op_vld  (op_vld),
    .i_ex_redirect (redirect),
    .o_fetch_en    (fetch_en),
    .o_iss_op      (iss_op),
    .o_iss_imm     (iss_imm),
    .o_iss_vld     (iss_vld),
    .i_iss_rdy     (rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every accepted issue must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && iss_vld && rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", {iss_op, iss_imm}, 32'hdead_beef);
      end else begin
        got = exp_q.pop_front();
        chk("sb_op", 32'(iss_op), 32'(got.op));
        chk("sb_imm", 32'(iss_imm), 32'(got.imm));
      end
    end
  end

  function automatic op_t mk(input alu_op_t a, input greg_t d, input rhs_src_t s, input greg_t r);
    op_t o;
    o.alu_op  = a;
    o.dst     = d;
    o.lhs     = ~d;
    o.rhs_src = s;
    o.rhs     = r;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nib(input sqi_data_t d, input logic v, input op_t o);
    enc = d; enc_vld = 1'b1; op_vld = v; op = o;
    step();
    enc_vld = 1'b0; op_vld = 1'b0;
  endtask

  task automatic opcode(input op_t o);
    for (int i = 0; i < 3; i++) nib(sqi_data_t'(i + 5), 1'b0, o);
    if (o.rhs_src != RHS_SRC_IMM) exp_q.push_back('{op: o, imm: 16'h0000});
    nib(4'hA, 1'b1, o);
  endtask

  task automatic imm_nibs(input op_t o, input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back('{op: o, imm: v});
      nib(v[4*i +: 4], 1'b0, o);
    end
  endtask

  op_t a1, ai, ca, cb, px, py, rz, rw, rv;

  initial begin
    a1 = mk(ALU_OP_ADD, 2'd1, RHS_SRC_REG, 2'd2);
    ai = mk(ALU_OP_ADD, 2'd2, RHS_SRC_IMM, 2'd0);
    ca = mk(ALU_OP_SUB, 2'd3, RHS_SRC_REG, 2'd1);
    cb = mk(ALU_OP_XOR, 2'd0, RHS_SRC_ZERO, 2'd3);
    px = mk(ALU_OP_AND, 2'd1, RHS_SRC_PC, 2'd0);
    py = mk(ALU_OP_OR, 2'd2, RHS_SRC_REG, 2'd3);
    rz = mk(ALU_OP_SHL, 2'd3, RHS_SRC_REG, 2'd2);
    rw = mk(ALU_OP_SUB, 2'd1, RHS_SRC_IMM, 2'd0);
    rv = mk(ALU_OP_XOR, 2'd2, RHS_SRC_IMM, 2'd1);

    // Reset values
    step(); step();
    chk("rst_vld", 32'(iss_vld), 32'd0);
    chk("rst_fetch_en", 32'(fetch_en), 32'd1);
    chk("rst_imm", 32'(iss_imm), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset mid-instruction: in IMM with two immediate nibbles taken
    opcode(ai);
    nib(4'h7, 1'b0, ai);
    nib(4'h8, 1'b0, ai);
    chk("mid_fetch_en", 32'(fetch_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(iss_vld), 32'd0);
    chk("mid_rst_fetch_en", 32'(fetch_en), 32'd1);
    chk("mid_rst_imm", 32'(iss_imm), 32'd0);
    exp_q.delete();
    step(); step();
    rst_n = 1'b1;

    // ADD with register rhs, one-cycle issue latency
    rdy = 1'b1;
    opcode(a1);
    chk("reg_vld", 32'(iss_vld), 32'd1);
    chk("reg_op", 32'(iss_op), 32'(a1));
    chk("reg_imm", 32'(iss_imm), 32'd0);
    step();
    chk("reg_vld_pulse", 32'(iss_vld), 32'd0);

    // ADD with immediate 0x1234, no issue during immediate nibbles
    opcode(ai);
    chk("imm_vld_op", 32'(iss_vld), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nib(sqi_data_t'(4 - i), 1'b0, ai);
      chk("imm_vld_mid", 32'(iss_vld), 32'd0);
    end
    exp_q.push_back('{op: ai, imm: 16'h1234});
    nib(4'h1, 1'b0, ai);
    chk("imm_vld", 32'(iss_vld), 32'd1);
    chk("imm_val", 32'(iss_imm), 32'h1234);
    chk("imm_op", 32'(iss_op), 32'(ai));
    step();
    chk("imm_vld_pulse", 32'(iss_vld), 32'd0);

    // Credit gating with execute stalled
    rdy = 1'b0;
    opcode(ca);
    chk("cr_fetch_en_c1", 32'(fetch_en), 32'd1);
    nib(4'h1, 1'b0, cb);
    chk("cr_fetch_en_infl", 32'(fetch_en), 32'd0);
    nib(4'h2, 1'b0, cb);
    nib(4'h3, 1'b0, cb);
    exp_q.push_back('{op: cb, imm: 16'h0000});
    nib(4'h4, 1'b1, cb);
    chk("cr_fetch_en_full", 32'(fetch_en), 32'd0);
    chk("cr_head_a", 32'(iss_op), 32'(ca));
    step();
    chk("cr_fetch_en_hold", 32'(fetch_en), 32'd0);
    rdy = 1'b1;
    chk("cr_fetch_en_popcyc", 32'(fetch_en), 32'd0);
    step();
    chk("cr_fetch_en_after", 32'(fetch_en), 32'd1);
    chk("cr_head_b", 32'(iss_op), 32'(cb));
    step();
    chk("cr_drained", 32'(iss_vld), 32'd0);

    // Push and pop together with one entry held
    rdy = 1'b0;
    opcode(px);
    nib(4'h1, 1'b0, py);
    nib(4'h2, 1'b0, py);
    nib(4'h3, 1'b0, py);
    exp_q.push_back('{op: py, imm: 16'h0000});
    rdy = 1'b1;
    nib(4'h4, 1'b1, py);
    chk("pp_vld", 32'(iss_vld), 32'd1);
    chk("pp_head", 32'(iss_op), 32'(py));
    chk("pp_fetch_en", 32'(fetch_en), 32'd1);
    step();
    chk("pp_drained", 32'(iss_vld), 32'd0);

    // Redirect on immediate nibble 2 with one entry and a pop
    rdy = 1'b0;
    opcode(rz);
    opcode(rw);
    nib(4'h9, 1'b0, rw);
    nib(4'h9, 1'b0, rw);
    enc = 4'h9; enc_vld = 1'b1; redirect = 1'b1; rdy = 1'b1;
    step();
    enc_vld = 1'b0; redirect = 1'b0;
    chk("rd_vld", 32'(iss_vld), 32'd0);
    chk("rd_fetch_en", 32'(fetch_en), 32'd1);
    chk("rd_sb_empty", 32'(exp_q.size()), 32'd0);
    opcode(rv);
    chk("rd_next_noissue", 32'(iss_vld), 32'd0);
    imm_nibs(rv, 16'hBEEF);
    chk("rd_next_vld", 32'(iss_vld), 32'd1);
    chk("rd_next_imm", 32'(iss_imm), 32'hBEEF);
    chk("rd_next_op", 32'(iss_op), 32'(rv));
    step();
    step();
    chk("end_vld", 32'(iss_vld), 32'd0);
    chk("end_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
